// File: rtl/feedbackloop_acc_sched.sv
// Four-lane round-robin burst scheduler feeding one shared 8-bit signed accumulator.
// Define FEEDBACKLOOP_SAT_EN to saturate accumulation; the default build wraps modulo 256.
module feedbackloop_acc_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_clr,
    input  logic        hold_i,
    output logic [7:0]  acc_o,
    output logic        acc_valid_o,
    output logic [1:0]  grant_id_o
);

    localparam logic [3:0] BL = 4'(BURST_LEN);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t         state, state_nxt;
    logic [1:0]     grant, grant_nxt;
    logic [1:0]     rr_ptr, rr_ptr_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [1:0]     pick, idx;
    logic           any_vld, xfer;
    logic [3:0][7:0] lane_data;
    logic [7:0]     opnd, add_res, acc_nxt;
    logic [8:0]     sum9;

    assign lane_data = req_data;

    // Scan from the highest offset down so the last hit is the first valid lane at/after rr_ptr.
    always_comb begin
        pick    = rr_ptr;
        any_vld = 1'b0;
        idx     = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (req_valid[idx]) begin
                pick    = idx;
                any_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        cnt_nxt    = cnt;
        rr_ptr_nxt = rr_ptr;
        req_ready  = '0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (!hold_i && any_vld) begin
                    state_nxt = SERVE;
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            SERVE: begin
                if (!hold_i) begin
                    req_ready[grant] = 1'b1;
                    if (req_valid[grant]) begin
                        xfer    = 1'b1;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt_nxt == BL) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = grant + 2'd1;
                        end
                    end else begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant + 2'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        opnd = lane_data[grant];
        sum9 = {acc_o[7], acc_o} + {opnd[7], opnd};
`ifdef FEEDBACKLOOP_SAT_EN
        // Sign bits disagree only on overflow; bit 8 holds the true sign.
        if (sum9[8] != sum9[7]) add_res = sum9[8] ? 8'h80 : 8'h7f;
        else                    add_res = sum9[7:0];
`else
        add_res = sum9[7:0];
`endif
        acc_nxt = req_clr[grant] ? opnd : add_res;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            acc_o       <= '0;
            acc_valid_o <= 1'b0;
            grant_id_o  <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cnt         <= cnt_nxt;
            acc_valid_o <= xfer;
            if (xfer) begin
                acc_o      <= acc_nxt;
                grant_id_o <= grant;
            end
        end
    end

endmodule

// File: tb/tb_feedbackloop_acc_sched.sv
// Randomized + directed bench for feedbackloop_acc_sched against a transaction-level model.
module tb_feedbackloop_acc_sched;

    localparam int BL = 4;

    logic        system1000 = 1'b0;
    logic        system1000_rstn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_data = '0;
    logic [3:0]  req_clr = '0;
    logic        hold_i = 1'b0;
    logic [7:0]  acc_o;
    logic        acc_valid_o;
    logic [1:0]  grant_id_o;

    int tests = 0;
    int fails = 0;

    // reference model: burst owner, transfers done in burst, next start lane, accumulator
    bit m_busy;
    int m_g, m_cnt, m_ptr, m_acc, m_gid;
    bit m_accv;

    feedbackloop_acc_sched #(.BURST_LEN(BL)) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_clr         (req_clr),
        .hold_i          (hold_i),
        .acc_o           (acc_o),
        .acc_valid_o     (acc_valid_o),
        .grant_id_o      (grant_id_o)
    );

    always #5 system1000 = ~system1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int to_s8(input int v);
        int w;
        w = v & 255;
        return (w > 127) ? w - 256 : w;
    endfunction

    function automatic int add_acc(input int a, input int d);
`ifdef FEEDBACKLOOP_SAT_EN
        if (a + d > 127)  return 127;
        if (a + d < -128) return -128;
        return a + d;
`else
        return to_s8(a + d);
`endif
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        m_acc = 0; m_accv = 0; m_gid = 0;
    endfunction

    function automatic void model_step();
        int d;
        m_accv = 0;
        if (hold_i) return;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (req_valid[(m_ptr + k) % 4]) begin
                    m_busy = 1;
                    m_g    = (m_ptr + k) % 4;
                    m_cnt  = 0;
                    break;
                end
            end
        end else if (req_valid[m_g]) begin
            d      = to_s8(int'(req_data[8*m_g +: 8]));
            m_acc  = req_clr[m_g] ? d : add_acc(m_acc, d);
            m_accv = 1;
            m_gid  = m_g;
            m_cnt++;
            if (m_cnt == BL) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % 4;
            end
        end else begin
            m_busy = 0;
            m_ptr  = (m_g + 1) % 4;
        end
    endfunction

    task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic [3:0] c, input logic h);
        @(negedge system1000);
        req_valid = v; req_data = d; req_clr = c; hold_i = h;
        #1;
        chk("ready", req_ready, (m_busy && !h) ? (32'd1 << m_g) : 32'd0);
        @(posedge system1000);
        model_step();
        #1;
        chk("acc", acc_o, m_acc & 255);
        chk("accv", acc_valid_o, m_accv);
        chk("gid", grant_id_o, m_gid);
    endtask

    task automatic do_reset();
        @(negedge system1000);
        system1000_rstn = 1'b0;
        req_valid = '0; req_clr = '0; hold_i = 1'b0;
        #1;
        model_reset();
        chk("rst_acc", acc_o, 0);
        chk("rst_accv", acc_valid_o, 0);
        chk("rst_gid", grant_id_o, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge system1000);
        system1000_rstn = 1'b1;
    endtask

    initial begin
        int npulse;
        logic [31:0] rd;
        model_reset();
        do_reset();

        // lane 0: 5, 3, -2
        cyc(4'b0001, 32'h05, 4'b0, 1'b0);
        cyc(4'b0001, 32'h05, 4'b0, 1'b0); chk("s28_a5", acc_o, 8'd5);
        cyc(4'b0001, 32'h03, 4'b0, 1'b0); chk("s28_a8", acc_o, 8'd8);
        cyc(4'b0001, 32'hfe, 4'b0, 1'b0); chk("s28_a6", acc_o, 8'd6);
        chk("s28_v", acc_valid_o, 1); chk("s28_g", grant_id_o, 0);
        cyc(4'b0000, 32'h0, 4'b0, 1'b0);

        // all lanes valid: round-robin order and one idle cycle between bursts
        do_reset();
        npulse = 0;
        for (int i = 0; i < 25; i++) begin
            rd = $urandom;
            cyc(4'hf, rd, 4'b0, 1'b0);
            if (acc_valid_o) begin
                chk("s29_gid", grant_id_o, (npulse / BL) % 4);
                npulse++;
            end
        end
        chk("s29_npulse", npulse, 20);

        // overflow on lane 2
        do_reset();
        cyc(4'b0100, 32'h007f0000, 4'b0100, 1'b0);
        cyc(4'b0100, 32'h007f0000, 4'b0100, 1'b0); chk("s30_127", acc_o, 8'h7f);
        cyc(4'b0100, 32'h00010000, 4'b0000, 1'b0);
`ifdef FEEDBACKLOOP_SAT_EN
        chk("s30_pos", acc_o, 8'h7f);
`else
        chk("s30_pos", acc_o, 8'h80);
`endif
        cyc(4'b0100, 32'h00800000, 4'b0100, 1'b0); chk("s30_m128", acc_o, 8'h80);
        cyc(4'b0100, 32'h00ff0000, 4'b0000, 1'b0);
`ifdef FEEDBACKLOOP_SAT_EN
        chk("s30_neg", acc_o, 8'h80);
`else
        chk("s30_neg", acc_o, 8'h7f);
`endif
        cyc(4'b0000, 32'h0, 4'b0, 1'b0);

        // clear-load on lane 1, then lane 3 clr without valid
        cyc(4'b0010, 32'h00003200, 4'b0010, 1'b0);
        cyc(4'b0010, 32'h00003200, 4'b0010, 1'b0); chk("s31_50", acc_o, 8'd50);
        cyc(4'b0010, 32'h00000a00, 4'b0010, 1'b0); chk("s31_10", acc_o, 8'd10);
        cyc(4'b0000, 32'h7f000000, 4'b1000, 1'b0);
        cyc(4'b0000, 32'h7f000000, 4'b1000, 1'b0);
        chk("s31_keep", acc_o, 8'd10); chk("s31_nov", acc_valid_o, 0);

        // hold mid-burst
        npulse = 0;
        cyc(4'b0001, 32'h1, 4'b0001, 1'b0);
        for (int i = 0; i < 2; i++) begin cyc(4'b0001, 32'h1, 4'b0, 1'b0); npulse += int'(acc_valid_o); end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 32'h1, 4'b0, 1'b1);
            chk("s32_hold_acc", acc_o, 8'd12);
        end
        for (int i = 0; i < 3; i++) begin cyc(4'b0001, 32'h1, 4'b0, 1'b0); npulse += int'(acc_valid_o); end
        chk("s32_burst", npulse, BL);
        chk("s32_acc", acc_o, 8'd14);

        // reset mid-burst, then restart from lane 0
        cyc(4'b0010, 32'h0300, 4'b0, 1'b0);
        cyc(4'b0010, 32'h0300, 4'b0, 1'b0);
        cyc(4'b0010, 32'h0300, 4'b0, 1'b0);
        do_reset();
        cyc(4'hf, 32'h04040404, 4'b0, 1'b0);
        cyc(4'hf, 32'h04040404, 4'b0, 1'b0);
        chk("s33_gid", grant_id_o, 0); chk("s33_acc", acc_o, 8'd4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            cyc(4'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 4'(1 << m_g) : 4'h0),
                rd, 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0),
                ($urandom_range(0, 7) == 0));
            if (i == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
